imem_loader: RTL and testbench

Boot and reload controller for the single-cycle-fetch RISC-V core. It receives a program as a byte stream from a UART receiver and writes it word by word into the core's 4096×32 instruction RAM write port. It holds the core in reset during loading and releases it once the last word is written. It sits between the UART RX block and the core's `rst_n` and instruction-RAM write port. It is the only writer of instruction RAM.

---
 rtl/imem_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot/reload controller: receives a length-prefixed little-endian program over a
// byte stream, writes it into instruction RAM and holds the core in reset meanwhile.
module imem_loader #(
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 4096,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              error
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0]   REM_ONE   = 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_CNT_LO,
        S_CNT_HI,
        S_LOAD,
        S_RUN,
        S_ERR
    } state_t;

    state_t              r_state;
    logic [7:0]          r_cnt_lo;
    logic [ADDR_W:0]     r_remaining;
    logic [1:0]          r_byte_idx;
    logic [ADDR_W-1:0]   r_word_addr;
    logic [23:0]         r_asm;
    logic [IDLE_W-1:0]   r_idle;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_cpu_rst_n;
    logic                r_busy;
    logic                r_error;

    logic [15:0]         w_count;
    logic [31:0]         w_word;
    logic                w_too_big;
    logic                w_timeout;

    assign w_count   = {rx_data, r_cnt_lo};
    assign w_word    = {rx_data, r_asm};
    assign w_too_big = ({16'd0, w_count} > 32'(DEPTH));
    // The idle cycle that would bring the count to TIMEOUT is the one that trips.
    assign w_timeout = !rx_valid && (r_idle == IDLE_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_CNT_LO;
            r_cnt_lo    <= '0;
            r_remaining <= '0;
            r_byte_idx  <= '0;
            r_word_addr <= '0;
            r_asm       <= '0;
            r_idle      <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rst_n <= 1'b0;
            r_busy      <= 1'b1;
            r_error     <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_CNT_LO: begin
                    if (rx_valid) begin
                        r_cnt_lo <= rx_data;
                        r_idle   <= '0;
                        r_state  <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (rx_valid) begin
                        if (w_count == '0) begin
                            r_state     <= S_RUN;
                            r_cpu_rst_n <= 1'b1;
                            r_busy      <= 1'b0;
                        end else if (w_too_big) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state     <= S_LOAD;
                            r_remaining <= w_count[ADDR_W:0];
                            r_word_addr <= '0;
                            r_byte_idx  <= '0;
                            r_idle      <= '0;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (rx_valid) begin
                        r_idle     <= '0;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_asm      <= {rx_data, r_asm[23:8]};
                        if (r_byte_idx == 2'd3) begin
                            r_we        <= 1'b1;
                            r_addr      <= r_word_addr;
                            r_wdata     <= w_word;
                            r_word_addr <= r_word_addr + 1'b1;
                            r_remaining <= r_remaining - 1'b1;
                            // Release waits one cycle in RUN so the core sees the final write.
                            if (r_remaining == REM_ONE) begin
                                r_state <= S_RUN;
                            end
                        end
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
                S_RUN: begin
                    if (load_req) begin
                        r_state     <= S_CNT_LO;
                        r_cpu_rst_n <= 1'b0;
                        r_busy      <= 1'b1;
                    end else begin
                        r_cpu_rst_n <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                S_ERR: begin
                    if (load_req) begin
                        r_state <= S_CNT_LO;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_CNT_LO;
                end
            endcase
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_rst_n  = r_cpu_rst_n;
    assign busy       = r_busy;
    assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a per-cycle vector table for the main load flows
// plus hand-written sequences for timeout, streaming and mid-load reset.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        load_req;
    logic        imem_we;
    logic [11:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        error;

    imem_loader #(
        .ADDR_W (12),
        .DEPTH  (4096),
        .TIMEOUT(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .load_req  (load_req),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        lr;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wd;
        logic        crst;
        logic        bsy;
        logic        err;
    } vec_t;

    vec_t        vecs[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [11:0] pa[$];
    logic [31:0] pd[$];
    int          pcyc[$];

    // Write-pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (imem_we === 1'b1) begin
            pa.push_back(imem_addr);
            pd.push_back(imem_wdata);
            pcyc.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic lr,
                       input logic we, input logic [11:0] a, input logic [31:0] wd,
                       input logic c, input logic b, input logic e);
        vecs.push_back('{v, d, lr, we, a, wd, c, b, e});
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic lr);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        load_req = lr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] outs();
        return {imem_we, imem_addr, imem_wdata, cpu_rst_n, busy, error};
    endfunction

    initial begin
        int          p0;
        logic [31:0] exp_w;
        logic [7:0]  b;

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        load_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we",    64'(imem_we),    64'(0));
        check("rst_addr",  64'(imem_addr),  64'(0));
        check("rst_wdata", 64'(imem_wdata), 64'(0));
        check("rst_cpu",   64'(cpu_rst_n),  64'(0));
        check("rst_busy",  64'(busy),       64'(1));
        check("rst_error", 64'(error),      64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // N=2 load
        add(1, 8'h02, 0, 0, 12'd0, 32'h0,        0, 1, 0);
        add(1, 8'h00, 0, 0, 12'd0, 32'h0,        0, 1, 0);
        add(1, 8'h13, 0, 0, 12'd0, 32'h0,        0, 1, 0);
        add(1, 8'h05, 0, 0, 12'd0, 32'h0,        0, 1, 0);
        add(1, 8'h10, 0, 0, 12'd0, 32'h0,        0, 1, 0);
        add(1, 8'h00, 0, 1, 12'd0, 32'h00100513, 0, 1, 0);
        add(1, 8'h73, 0, 0, 12'd0, 32'h00100513, 0, 1, 0);
        add(1, 8'h00, 0, 0, 12'd0, 32'h00100513, 0, 1, 0);
        add(1, 8'h10, 0, 0, 12'd0, 32'h00100513, 0, 1, 0);
        add(1, 8'h00, 0, 1, 12'd1, 32'h00100073, 0, 1, 0);
        add(0, 8'h00, 0, 0, 12'd1, 32'h00100073, 1, 0, 0);
        // bytes in RUN ignored
        add(1, 8'hAA, 0, 0, 12'd1, 32'h00100073, 1, 0, 0);
        add(1, 8'hBB, 0, 0, 12'd1, 32'h00100073, 1, 0, 0);
        // load_req with a byte in RUN: byte not used as count low
        add(1, 8'hFF, 1, 0, 12'd1, 32'h00100073, 0, 1, 0);
        add(1, 8'h01, 0, 0, 12'd1, 32'h00100073, 0, 1, 0);
        add(1, 8'h00, 0, 0, 12'd1, 32'h00100073, 0, 1, 0);
        add(1, 8'hEF, 0, 0, 12'd1, 32'h00100073, 0, 1, 0);
        add(1, 8'hBE, 1, 0, 12'd1, 32'h00100073, 0, 1, 0);
        add(1, 8'hAD, 0, 0, 12'd1, 32'h00100073, 0, 1, 0);
        add(1, 8'hDE, 0, 1, 12'd0, 32'hDEADBEEF, 0, 1, 0);
        add(0, 8'h00, 0, 0, 12'd0, 32'hDEADBEEF, 1, 0, 0);
        // N=0
        add(0, 8'h00, 1, 0, 12'd0, 32'hDEADBEEF, 0, 1, 0);
        add(1, 8'h00, 0, 0, 12'd0, 32'hDEADBEEF, 0, 1, 0);
        add(1, 8'h00, 0, 0, 12'd0, 32'hDEADBEEF, 1, 0, 0);
        add(0, 8'h00, 0, 0, 12'd0, 32'hDEADBEEF, 1, 0, 0);
        // N=4097 -> error, then recover with N=1
        add(0, 8'h00, 1, 0, 12'd0, 32'hDEADBEEF, 0, 1, 0);
        add(1, 8'h01, 0, 0, 12'd0, 32'hDEADBEEF, 0, 1, 0);
        add(1, 8'h10, 0, 0, 12'd0, 32'hDEADBEEF, 0, 0, 1);
        add(1, 8'h55, 0, 0, 12'd0, 32'hDEADBEEF, 0, 0, 1);
        add(0, 8'h00, 1, 0, 12'd0, 32'hDEADBEEF, 0, 1, 0);
        add(1, 8'h01, 0, 0, 12'd0, 32'hDEADBEEF, 0, 1, 0);
        add(1, 8'h00, 0, 0, 12'd0, 32'hDEADBEEF, 0, 1, 0);
        add(1, 8'h11, 0, 0, 12'd0, 32'hDEADBEEF, 0, 1, 0);
        add(1, 8'h22, 1, 0, 12'd0, 32'hDEADBEEF, 0, 1, 0);
        add(1, 8'h33, 0, 0, 12'd0, 32'hDEADBEEF, 0, 1, 0);
        add(1, 8'h44, 0, 1, 12'd0, 32'h44332211, 0, 1, 0);
        add(0, 8'h00, 0, 0, 12'd0, 32'h44332211, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].lr);
            check($sformatf("vec%0d", i), 64'(outs()),
                  64'({vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].crst, vecs[i].bsy, vecs[i].err}));
        end

        // Timeout: N=3, five bytes then silence
        step(0, 8'h00, 1);
        step(1, 8'h03, 0);
        step(1, 8'h00, 0);
        p0 = pa.size();
        for (int k = 1; k <= 5; k++) step(1, 8'(k), 0);
        repeat (15) step(0, 8'h00, 0);
        check("to_err_early", 64'(error), 64'(0));
        step(0, 8'h00, 0);
        check("to_err",    64'(error),      64'(1));
        check("to_cpu",    64'(cpu_rst_n),  64'(0));
        check("to_busy",   64'(busy),       64'(0));
        check("to_writes", 64'(pa.size()),  64'(p0 + 1));
        if (pa.size() == p0 + 1) begin
            check("to_addr", 64'(pa[p0]), 64'(0));
            check("to_data", 64'(pd[p0]), 64'h04030201);
        end

        // Back-to-back stream, N=4
        step(0, 8'h00, 1);
        pa.delete();
        pd.delete();
        pcyc.delete();
        step(1, 8'h04, 0);
        step(1, 8'h00, 0);
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 4; k++) step(1, 8'(8'h40 + w * 4 + k), 0);
        step(0, 8'h00, 0);
        check("bb_cpu",    64'(cpu_rst_n), 64'(1));
        check("bb_busy",   64'(busy),      64'(0));
        check("bb_writes", 64'(pa.size()), 64'(4));
        for (int w = 0; w < 4 && w < pa.size(); w++) begin
            exp_w = '0;
            for (int k = 3; k >= 0; k--) begin
                b     = 8'(8'h40 + w * 4 + k);
                exp_w = {exp_w[23:0], b};
            end
            check($sformatf("bb_addr%0d", w), 64'(pa[w]), 64'(w));
            check($sformatf("bb_data%0d", w), 64'(pd[w]), 64'(exp_w));
            if (w > 0) check($sformatf("bb_gap%0d", w), 64'(pcyc[w] - pcyc[w-1]), 64'(4));
        end
        check("bb_last_addr", 64'(imem_addr), 64'(3));

        // Reset mid-word on a second load
        step(0, 8'h00, 1);
        step(1, 8'h01, 0);
        step(1, 8'h00, 0);
        step(1, 8'hA1, 0);
        step(1, 8'hA2, 0);
        @(negedge clk);
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        load_req = 1'b0;
        @(posedge clk);
        #1;
        check("mr_we",   64'(imem_we),   64'(0));
        check("mr_busy", 64'(busy),      64'(1));
        check("mr_cpu",  64'(cpu_rst_n), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        p0 = pa.size();
        // In CNT_LO these form an N=0 header; a stale LOAD would instead complete the word.
        step(1, 8'h00, 0);
        step(1, 8'h00, 0);
        check("mr_release", 64'(cpu_rst_n), 64'(1));
        step(0, 8'h00, 0);
        check("mr_nowrite", 64'(pa.size()), 64'(p0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
